// File: rtl/foo.sv
// -----------------------------------------------------------------------------
// foo: synchronous first-word-fall-through FIFO.
//
// Ports:
//   reset_n    in   async active-low reset (clears pointers, count, flags)
//   clock      in   rising-edge clock
//   wr_en      in   push request
//   wr_data    in   push data [WIDTH]
//   rd_en      in   pop request
//   rd_data    out  head-of-queue data [WIDTH], valid while empty=0
//   full       out  queue holds DEPTH entries
//   empty      out  queue holds no entries
//   count      out  occupancy [log2(DEPTH)+1]
//   overflow   out  sticky: a push was rejected
//   underflow  out  sticky: a pop was rejected
// -----------------------------------------------------------------------------
module foo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     reset_n,
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("foo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // A pop frees a slot in the same cycle, so a push into a full queue is
  // accepted when paired with a pop.
  assign pop_ok  = rd_en & ~empty;
  assign push_ok = wr_en & (~full | pop_ok);

  // Next-state logic. An X on wr_en/rd_en makes push_ok/pop_ok X, which the
  // if-statements resolve to the else path: no state change.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (push_ok && !pop_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (AW+1)'(1);
    end

    if (wr_en && !push_ok) begin
      overflow_d = 1'b1;
    end
    if (rd_en && empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; writes are blocked while reset_n is low
  // so a push on a reset edge leaves nothing behind.
  always_ff @(posedge clock) begin
    if (push_ok && reset_n) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_foo.sv
module tb_foo;

  logic       reset_n;
  logic       clock;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int n_tests;
  int n_fail;

  foo #(.WIDTH(8), .DEPTH(4)) dut (
    .reset_n   (reset_n),
    .clock     (clock),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request for the next rising edge, then idle the inputs.
  task automatic op(input logic w, input logic [7:0] d, input logic r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic [2:0] c, input logic f,
                             input logic e, input logic ov, input logic un);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".full"}, 32'(full), 32'(f));
    check({tag, ".empty"}, 32'(empty), 32'(e));
    check({tag, ".ovf"}, 32'(overflow), 32'(ov));
    check({tag, ".udf"}, 32'(underflow), 32'(un));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 8'h00;

    #10;
    check_flags("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    begin
      logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) op(1'b1, fill[i], 1'b0);
      check_flags("fill4", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);

      op(1'b1, 8'h55, 1'b0);
      check_flags("push_full", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 4; i++) begin
        check($sformatf("drain%0d", i), 32'(rd_data), 32'(fill[i]));
        op(1'b0, 8'h00, 1'b1);
      end
      check_flags("drained", 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    end

    op(1'b0, 8'h00, 1'b1);
    check_flags("pop_empty", 3'd0, 1'b0, 1'b1, 1'b1, 1'b1);

    op(1'b1, 8'hA5, 1'b1);
    check_flags("pushpop_empty", 3'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("pushpop_empty.data", 32'(rd_data), 32'h0000_00A5);

    op(1'b1, 8'hB1, 1'b0);
    op(1'b1, 8'hB2, 1'b0);
    check("pre_reset.count", 32'(count), 32'd3);

    // Asynchronous reset mid-cycle, sampled before the next rising edge.
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check_flags("async_rst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // A push presented on an edge while reset is held is ignored.
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    check_flags("push_in_rst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    begin
      logic [7:0] fill [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
      for (int i = 0; i < 4; i++) op(1'b1, fill[i], 1'b0);
      check_flags("refill", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      check("refill.head", 32'(rd_data), 32'h01);

      op(1'b1, 8'h66, 1'b1);
      check_flags("pushpop_full", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    begin
      logic [7:0] exp_seq [4] = '{8'h02, 8'h03, 8'h04, 8'h66};
      for (int i = 0; i < 4; i++) begin
        check($sformatf("wrap%0d", i), 32'(rd_data), 32'(exp_seq[i]));
        op(1'b0, 8'h00, 1'b1);
      end
      check_flags("wrap_done", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
